// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the two-stage Mem pipe among NUM_REQ load/store requesters,
// routing writebacks to their issuer and sequencing the RAM-load window. Optional: MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_readmem,
  input  logic [NUM_REQ-1:0]      req_writemem,
  input  logic [NUM_REQ-1:0]      req_writereg,
  input  logic [32*NUM_REQ-1:0]   req_rega,
  input  logic [32*NUM_REQ-1:0]   req_imedext,
  input  logic [32*NUM_REQ-1:0]   req_regb,
  input  logic [5*NUM_REQ-1:0]    req_regdest,
  input  logic                    load_req,
  output logic                    load_active,
  output logic                    arb_mem_oper,
  output logic                    arb_mem_readmem,
  output logic                    arb_mem_writemem,
  output logic                    arb_mem_writereg,
  output logic [31:0]             arb_mem_rega,
  output logic [31:0]             arb_mem_imedext,
  output logic [31:0]             arb_mem_regb,
  output logic [4:0]              arb_mem_regdest,
  input  logic                    mem_wb_writereg,
  input  logic [4:0]              mem_wb_regdest,
  input  logic [31:0]             mem_wb_wbvalue,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [4:0]              rsp_regdest,
  output logic [31:0]             rsp_wbvalue,
`ifdef MEM_ARB_PERF_EN
  output logic [32*NUM_REQ-1:0]   perf_grant_cnt,
`endif
  output logic                    arb_err
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] arb_id_q;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_idx;
  logic           win_found;
  logic           accept;
  logic           pipe_busy;
  tag_t           tag_q [MEM_LATENCY];
  tag_t           tail;

  // First valid requester at or after the round-robin pointer
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
  end

  assign tail = tag_q[MEM_LATENCY-1];

  // Next-state and grant; load_req pre-empts any same-cycle grant
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      ST_RUN: begin
        if (load_req) begin
          state_d = ST_DRAIN;
        end else if (win_found) begin
          req_ready = NUM_REQ'(1) << win_id;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy && !arb_mem_oper) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!load_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      load_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_active <= (state_d == ST_LOAD);
    end
  end

  // Issue register toward Mem; data fields hold when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q            <= '0;
      arb_id_q         <= '0;
      arb_mem_oper     <= 1'b0;
      arb_mem_readmem  <= 1'b0;
      arb_mem_writemem <= 1'b0;
      arb_mem_writereg <= 1'b0;
      arb_mem_rega     <= '0;
      arb_mem_imedext  <= '0;
      arb_mem_regb     <= '0;
      arb_mem_regdest  <= '0;
    end else begin
      arb_mem_oper     <= accept;
      arb_mem_readmem  <= accept & req_readmem[win_id];
      arb_mem_writemem <= accept & req_writemem[win_id];
      arb_mem_writereg <= accept & req_writereg[win_id];
      if (accept) begin
        arb_mem_rega    <= req_rega[32*win_id +: 32];
        arb_mem_imedext <= req_imedext[32*win_id +: 32];
        arb_mem_regb    <= req_regb[32*win_id +: 32];
        arb_mem_regdest <= req_regdest[5*win_id +: 5];
        arb_id_q        <= win_id;
        ptr_q           <= IDW'((32'(win_id) + 32'd1) % NUM_REQ);
      end
    end
  end

  // Owner tags ride alongside the Mem pipe so the tail lines up with mem_wb_*
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
      arb_err <= 1'b0;
    end else begin
      tag_q[0] <= '{valid: arb_mem_oper, id: arb_id_q};
      for (int unsigned i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (mem_wb_writereg && !tail.valid) arb_err <= 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tail.valid && mem_wb_writereg) rsp_valid = NUM_REQ'(1) << tail.id;
  end

  assign rsp_regdest = mem_wb_regdest;
  assign rsp_wbvalue = mem_wb_wbvalue;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          perf_grant_cnt[32*i +: 32] <= perf_grant_cnt[32*i +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small two-stage Mem model driving mem_wb_*.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_REQ = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_readmem, req_writemem, req_writereg;
  logic [32*NUM_REQ-1:0] req_rega, req_imedext, req_regb;
  logic [5*NUM_REQ-1:0]  req_regdest;
  logic                  load_req, load_active;
  logic                  arb_mem_oper, arb_mem_readmem, arb_mem_writemem, arb_mem_writereg;
  logic [31:0]           arb_mem_rega, arb_mem_imedext, arb_mem_regb;
  logic [4:0]            arb_mem_regdest;
  logic                  mem_wb_writereg;
  logic [4:0]            mem_wb_regdest;
  logic [31:0]           mem_wb_wbvalue;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [4:0]            rsp_regdest;
  logic [31:0]           rsp_wbvalue;
  logic                  arb_err;
`ifdef MEM_ARB_PERF_EN
  logic [32*NUM_REQ-1:0] perf_grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic force_wb;

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .MEM_LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_readmem(req_readmem), .req_writemem(req_writemem), .req_writereg(req_writereg),
    .req_rega(req_rega), .req_imedext(req_imedext), .req_regb(req_regb),
    .req_regdest(req_regdest),
    .load_req(load_req), .load_active(load_active),
    .arb_mem_oper(arb_mem_oper), .arb_mem_readmem(arb_mem_readmem),
    .arb_mem_writemem(arb_mem_writemem), .arb_mem_writereg(arb_mem_writereg),
    .arb_mem_rega(arb_mem_rega), .arb_mem_imedext(arb_mem_imedext),
    .arb_mem_regb(arb_mem_regb), .arb_mem_regdest(arb_mem_regdest),
    .mem_wb_writereg(mem_wb_writereg), .mem_wb_regdest(mem_wb_regdest),
    .mem_wb_wbvalue(mem_wb_wbvalue),
    .rsp_valid(rsp_valid), .rsp_regdest(rsp_regdest), .rsp_wbvalue(rsp_wbvalue),
`ifdef MEM_ARB_PERF_EN
    .perf_grant_cnt(perf_grant_cnt),
`endif
    .arb_err(arb_err)
  );

  always #5 clock = ~clock;

  // Mem model: two register stages, wbvalue = effective address
  logic        s1_oper, s1_wr, s2_oper, s2_wr;
  logic [4:0]  s1_rd, s2_rd;
  logic [31:0] s1_val, s2_val;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_oper <= 1'b0; s1_wr <= 1'b0; s1_rd <= '0; s1_val <= '0;
      s2_oper <= 1'b0; s2_wr <= 1'b0; s2_rd <= '0; s2_val <= '0;
    end else begin
      s1_oper <= arb_mem_oper;
      s1_wr   <= arb_mem_writereg;
      s1_rd   <= arb_mem_regdest;
      s1_val  <= arb_mem_rega + arb_mem_imedext;
      s2_oper <= s1_oper;
      s2_wr   <= s1_wr;
      s2_rd   <= s1_rd;
      s2_val  <= s1_val;
    end
  end

  assign mem_wb_writereg = force_wb | (s2_oper & s2_wr);
  assign mem_wb_regdest  = s2_rd;
  assign mem_wb_wbvalue  = s2_val;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rd, input logic wm, input logic wr,
                         input logic [31:0] a, input logic [31:0] imm,
                         input logic [31:0] b, input logic [4:0] dst);
    req_readmem[i]         = rd;
    req_writemem[i]        = wm;
    req_writereg[i]        = wr;
    req_rega[32*i +: 32]   = a;
    req_imedext[32*i +: 32] = imm;
    req_regb[32*i +: 32]   = b;
    req_regdest[5*i +: 5]  = dst;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    req_valid    = '0;
    req_readmem  = '0;
    req_writemem = '0;
    req_writereg = '0;
    req_rega     = '0;
    req_imedext  = '0;
    req_regb     = '0;
    req_regdest  = '0;
    load_req     = 1'b0;
    force_wb     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge clock);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_oper", 64'(arb_mem_oper), 64'd0);
    check("rst_load_active", 64'(load_active), 64'd0);
    check("rst_err", 64'(arb_err), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);

    // Single load from requester 0
    next_cycle();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h4, 32'h0, 5'd5);
    req_valid = 2'b01;
    @(negedge clock);
    check("t1_ready", 64'(req_ready), 64'd1);
    next_cycle();
    req_valid = '0;
    @(negedge clock);
    check("t1_oper", 64'(arb_mem_oper), 64'd1);
    check("t1_readmem", 64'(arb_mem_readmem), 64'd1);
    check("t1_rega", 64'(arb_mem_rega), 64'h10);
    check("t1_imm", 64'(arb_mem_imedext), 64'h4);
    check("t1_rd", 64'(arb_mem_regdest), 64'd5);
    next_cycle();
    @(negedge clock);
    check("t1_oper_drop", 64'(arb_mem_oper), 64'd0);
    check("t1_rsp_early", 64'(rsp_valid), 64'd0);
    next_cycle();
    @(negedge clock);
    check("t1_rsp", 64'(rsp_valid), 64'd1);
    check("t1_rsp_rd", 64'(rsp_regdest), 64'd5);
    check("t1_rsp_val", 64'(rsp_wbvalue), 64'h14);

    // Two requesters continuously valid for six cycles
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h1, 32'h0, 5'd3);
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h2, 32'h0, 5'd7);
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) req_valid = '0;
      @(negedge clock);
      check($sformatf("t2_ready_c%0d", c), 64'(req_ready),
            (c < 6) ? ((c % 2 == 1) ? 64'd2 : 64'd1) : 64'd0);
      check($sformatf("t2_oper_c%0d", c), 64'(arb_mem_oper),
            (c >= 1 && c <= 6) ? 64'd1 : 64'd0);
      if (c >= 3 && c <= 8) begin
        check($sformatf("t2_rsp_c%0d", c), 64'(rsp_valid),
              ((c - 3) % 2 == 1) ? 64'd2 : 64'd1);
        check($sformatf("t2_rsp_rd_c%0d", c), 64'(rsp_regdest),
              ((c - 3) % 2 == 1) ? 64'd7 : 64'd3);
        check($sformatf("t2_rsp_val_c%0d", c), 64'(rsp_wbvalue),
              ((c - 3) % 2 == 1) ? 64'h202 : 64'h101);
      end else begin
        check($sformatf("t2_rsp_c%0d", c), 64'(rsp_valid), 64'd0);
      end
      next_cycle();
    end
`ifdef MEM_ARB_PERF_EN
    check("t6_perf0", 64'(perf_grant_cnt[31:0]), 64'd3);
    check("t6_perf1", 64'(perf_grant_cnt[63:32]), 64'd3);
`endif

    // Store from requester 1, then load from requester 0
    set_req(1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 32'hdead, 5'd11);
    req_valid = 2'b10;
    @(negedge clock);
    check("t3_ready_st", 64'(req_ready), 64'd2);
    next_cycle();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h8, 32'h0, 5'd9);
    req_valid = 2'b01;
    @(negedge clock);
    check("t3_ready_ld", 64'(req_ready), 64'd1);
    check("t3_writemem", 64'(arb_mem_writemem), 64'd1);
    check("t3_writereg", 64'(arb_mem_writereg), 64'd0);
    check("t3_regb", 64'(arb_mem_regb), 64'hdead);
    next_cycle();
    req_valid = '0;
    @(negedge clock);
    check("t3_ld_oper", 64'(arb_mem_readmem), 64'd1);
    next_cycle();
    @(negedge clock);
    check("t3_st_no_rsp", 64'(rsp_valid), 64'd0);
    next_cycle();
    @(negedge clock);
    check("t3_ld_rsp", 64'(rsp_valid), 64'd1);
    check("t3_ld_rd", 64'(rsp_regdest), 64'd9);
    check("t3_ld_val", 64'(rsp_wbvalue), 64'h48);

    // Load window with two ops in flight; pointer now favours requester 1
    next_cycle();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h0, 32'h0, 5'd1);
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h0, 32'h0, 5'd2);
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) load_req = 1'b1;
      if (c == 8) load_req = 1'b0;
      @(negedge clock);
      check($sformatf("t4_ready_c%0d", c), 64'(req_ready),
            (c == 0 || c == 9) ? 64'd2 : ((c == 1) ? 64'd1 : 64'd0));
      check($sformatf("t4_load_active_c%0d", c), 64'(load_active),
            (c >= 6 && c <= 8) ? 64'd1 : 64'd0);
      if (c == 3 || c == 4) begin
        check($sformatf("t4_rsp_c%0d", c), 64'(rsp_valid), (c == 3) ? 64'd2 : 64'd1);
        check($sformatf("t4_rsp_rd_c%0d", c), 64'(rsp_regdest), (c == 3) ? 64'd2 : 64'd1);
      end
      if (c == 2) check("t4_oper_c2", 64'(arb_mem_oper), 64'd1);
      if (c == 3) check("t4_oper_c3", 64'(arb_mem_oper), 64'd0);
      next_cycle();
    end

    // Writeback with nothing in flight
    do_reset();
    @(negedge clock);
    check("t5_err_init", 64'(arb_err), 64'd0);
    next_cycle();
    force_wb = 1'b1;
    @(negedge clock);
    check("t5_no_rsp", 64'(rsp_valid), 64'd0);
    check("t5_err_pre", 64'(arb_err), 64'd0);
    next_cycle();
    force_wb = 1'b0;
    @(negedge clock);
    check("t5_err_set", 64'(arb_err), 64'd1);
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("t5_err_sticky", 64'(arb_err), 64'd1);
    reset = 1'b0;
    #1;
    check("t5_err_async_clr", 64'(arb_err), 64'd0);
    check("t5_load_active_clr", 64'(load_active), 64'd0);
    next_cycle();
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
